// File: rtl/bcd_timer_pkg.sv
// -----------------------------------------------------------------------------
// bcd_timer_pkg
// Shared definitions for the BCD cook-timer chain.
//   DIGIT_W   : bits per BCD digit
//   state_t   : run/expire FSM state encoding (IDLE, ARMED, RUNNING, EXPIRED)
//   digit_max : extracts the per-digit maximum for digit idx from the packed
//               DIGIT_MAX parameter (digit 0 in the low nibble)
// -----------------------------------------------------------------------------
package bcd_timer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Packed maxima are passed zero-extended to 64 bits (up to 16 digits).
    function automatic logic [DIGIT_W-1:0] digit_max(input logic [63:0] maxes,
                                                     input int idx);
        return maxes[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One down-counting digit of the timer chain.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset, clears the digit
//   load      : synchronous load of load_val (beats any decrement)
//   load_val  : value stored on load
//   max_val   : value reloaded when the digit borrows from zero
//   borrow_in : all lower digits are zero (digit 0 ties this high)
//   dec_en    : a decrement of the whole chain happens this cycle
//   digit     : registered digit value
//   is_zero   : digit == 0, feeds the next digit's borrow
// -----------------------------------------------------------------------------
module bcd_digit_cell
    import bcd_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic [DIGIT_W-1:0] max_val,
    input  logic               borrow_in,
    input  logic               dec_en,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_en && borrow_in) begin
            // Plain binary decrement; an over-range digit walks down until
            // it reaches zero and then reloads its maximum.
            if (digit == '0) digit <= max_val;
            else             digit <= digit - 1'b1;
        end
    end

    assign is_zero = (digit == '0);

endmodule

// File: rtl/bcd_timer_chain.sv
// -----------------------------------------------------------------------------
// bcd_timer_chain
// Multi-digit BCD down-counter for the cook timer, with run/expire FSM.
// Optional build macro: BCD_TIMER_CLAMP_EN -- when defined, each loaded digit
// above its maximum is stored as that maximum; otherwise data is stored as-is.
// Parameters:
//   NUM_DIGITS : cascaded digits, digit 0 least significant
//   DIGIT_MAX  : packed per-digit maxima (reload value on borrow)
//   WRAP_EN    : 0 = stop at zero (EXPIRED), 1 = wrap to all-max and keep going
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   load      : synchronous load of data (priority over decrement)
//   data      : BCD preset
//   run       : level, 1 = count, 0 = pause
//   tick      : one-cycle time-base strobe
//   count     : registered BCD value
//   tc        : combinational, count == 0
//   busy      : state == RUNNING
//   done      : registered one-cycle pulse when a decrement reaches zero
//   state_dbg : current FSM state, for observation
// -----------------------------------------------------------------------------
module bcd_timer_chain
    import bcd_timer_pkg::*;
#(
    parameter int                            NUM_DIGITS = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h9959,
    parameter bit                            WRAP_EN    = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
    input  logic                          run,
    input  logic                          tick,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          tc,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    state_dbg
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    state_t              state;
    logic [W-1:0]        load_val;
    logic [NUM_DIGITS-1:0] zero_vec;
    logic [NUM_DIGITS-1:0] borrow;
    logic                dec;
    logic                hits_zero;

    // A tick decrements only while running with run still high this cycle;
    // a coincident load or falling run swallows the tick.
    assign dec       = (state == RUNNING) && run && tick && !load;
    assign hits_zero = dec && (count == W'(1));

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam logic [DIGIT_W-1:0] MAXD = digit_max(64'(DIGIT_MAX), i);
        logic [DIGIT_W-1:0] d_in;

        assign d_in = data[i*DIGIT_W +: DIGIT_W];
`ifdef BCD_TIMER_CLAMP_EN
        assign load_val[i*DIGIT_W +: DIGIT_W] = (d_in > MAXD) ? MAXD : d_in;
`else
        assign load_val[i*DIGIT_W +: DIGIT_W] = d_in;
`endif

        if (i < NUM_DIGITS - 1) begin : g_chain
            assign borrow[i+1] = borrow[i] & zero_vec[i];
        end

        bcd_digit_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .load_val  (load_val[i*DIGIT_W +: DIGIT_W]),
            .max_val   (MAXD),
            .borrow_in (borrow[i]),
            .dec_en    (dec),
            .digit     (count[i*DIGIT_W +: DIGIT_W]),
            .is_zero   (zero_vec[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else if (load) begin
            state <= (load_val != '0) ? ARMED : IDLE;
            done  <= 1'b0;
        end else begin
            done <= hits_zero;
            case (state)
                IDLE:    state <= IDLE;
                ARMED:   if (run) state <= RUNNING;
                RUNNING: begin
                    if (!run)                       state <= ARMED;
                    else if (hits_zero && !WRAP_EN) state <= EXPIRED;
                end
                EXPIRED: if (!run) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign tc        = (count == '0);
    assign busy      = (state == RUNNING);
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_timer_chain.sv
module tb_bcd_timer_chain;
    import bcd_timer_pkg::*;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic        run;
    logic        tick;

    logic [15:0] count;
    logic        tc, busy, done;
    logic [1:0]  state_dbg;

    logic [15:0] w_count;
    logic        w_tc, w_busy, w_done;
    logic [1:0]  w_state;

    int total = 0;
    int bad   = 0;

    bcd_timer_chain u_dut (
        .clk(clk), .reset(reset), .load(load), .data(data), .run(run), .tick(tick),
        .count(count), .tc(tc), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    bcd_timer_chain #(.WRAP_EN(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .load(load), .data(data), .run(run), .tick(tick),
        .count(w_count), .tc(w_tc), .busy(w_busy), .done(w_done), .state_dbg(w_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d);
        load = 1'b1;
        data = d;
        step();
        load = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        step();
        total++; if (count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=%h", count, 16'h0000); end
        total++; if (tc !== 1'b1) begin bad++; $display("FAIL reset_tc got=%b exp=1", tc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
        reset = 1'b1;
        step();
        // run is ignored in IDLE
        run = 1'b1;
        step();
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL idle_ignores_run got=%0d exp=%0d", state_dbg, IDLE); end
        run = 1'b0;
        step();
    endtask

    task automatic test_basic_expire();
        do_load(16'h0003);
        total++; if (count !== 16'h0003) begin bad++; $display("FAIL basic_load got=%h exp=%h", count, 16'h0003); end
        total++; if (state_dbg !== ARMED) begin bad++; $display("FAIL basic_armed got=%0d exp=%0d", state_dbg, ARMED); end
        run = 1'b1;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        do_tick();
        total++; if (count !== 16'h0002) begin bad++; $display("FAIL basic_t1 got=%h exp=%h", count, 16'h0002); end
        do_tick();
        total++; if (count !== 16'h0001) begin bad++; $display("FAIL basic_t2 got=%h exp=%h", count, 16'h0001); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b exp=0", done); end
        do_tick();
        total++; if (count !== 16'h0000) begin bad++; $display("FAIL basic_t3 got=%h exp=%h", count, 16'h0000); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
        total++; if (state_dbg !== EXPIRED) begin bad++; $display("FAIL basic_expired got=%0d exp=%0d", state_dbg, EXPIRED); end
        total++; if (tc !== 1'b1) begin bad++; $display("FAIL basic_tc got=%b exp=1", tc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_exp got=%b exp=0", busy); end
        do_tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_one_cycle got=%b exp=0", done); end
        total++; if (count !== 16'h0000) begin bad++; $display("FAIL basic_hold_zero got=%h exp=%h", count, 16'h0000); end
        total++; if (state_dbg !== EXPIRED) begin bad++; $display("FAIL basic_stay_expired got=%0d exp=%0d", state_dbg, EXPIRED); end
        run = 1'b0;
        step();
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL basic_to_idle got=%0d exp=%0d", state_dbg, IDLE); end
    endtask

    task automatic test_borrow();
        do_load(16'h0100);
        run = 1'b1;
        step();
        do_tick();
        total++; if (count !== 16'h0059) begin bad++; $display("FAIL borrow_0100 got=%h exp=%h", count, 16'h0059); end
        do_load(16'h1000);
        step();
        do_tick();
        total++; if (count !== 16'h0959) begin bad++; $display("FAIL borrow_1000 got=%h exp=%h", count, 16'h0959); end
        run = 1'b0;
        step();
    endtask

    task automatic test_pause();
        do_load(16'h0010);
        run = 1'b1;
        step();
        do_tick();
        total++; if (count !== 16'h0009) begin bad++; $display("FAIL pause_t1 got=%h exp=%h", count, 16'h0009); end
        do_tick();
        total++; if (count !== 16'h0008) begin bad++; $display("FAIL pause_t2 got=%h exp=%h", count, 16'h0008); end
        run = 1'b0;
        step();
        total++; if (state_dbg !== ARMED) begin bad++; $display("FAIL pause_armed got=%0d exp=%0d", state_dbg, ARMED); end
        for (int i = 0; i < 5; i++) do_tick();
        total++; if (count !== 16'h0008) begin bad++; $display("FAIL pause_hold got=%h exp=%h", count, 16'h0008); end
        run = 1'b1;
        step();
        do_tick();
        total++; if (count !== 16'h0007) begin bad++; $display("FAIL pause_resume got=%h exp=%h", count, 16'h0007); end
        // run falling together with tick: tick dropped
        run  = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        total++; if (count !== 16'h0007) begin bad++; $display("FAIL pause_fall_tick got=%h exp=%h", count, 16'h0007); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pause_fall_busy got=%b exp=0", busy); end
    endtask

    task automatic test_wrap();
        do_load(16'h0001);
        run = 1'b1;
        step();
        do_tick();
        total++; if (w_count !== 16'h0000) begin bad++; $display("FAIL wrap_t1 got=%h exp=%h", w_count, 16'h0000); end
        total++; if (w_done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", w_done); end
        total++; if (w_busy !== 1'b1) begin bad++; $display("FAIL wrap_busy1 got=%b exp=1", w_busy); end
        total++; if (w_tc !== 1'b1) begin bad++; $display("FAIL wrap_tc got=%b exp=1", w_tc); end
        step();
        total++; if (w_done !== 1'b0) begin bad++; $display("FAIL wrap_done_pulse got=%b exp=0", w_done); end
        do_tick();
        total++; if (w_count !== 16'h9959) begin bad++; $display("FAIL wrap_t2 got=%h exp=%h", w_count, 16'h9959); end
        total++; if (w_busy !== 1'b1) begin bad++; $display("FAIL wrap_busy2 got=%b exp=1", w_busy); end
        total++; if (w_state !== RUNNING) begin bad++; $display("FAIL wrap_state got=%0d exp=%0d", w_state, RUNNING); end
        total++; if (count !== 16'h0000) begin bad++; $display("FAIL nowrap_hold got=%h exp=%h", count, 16'h0000); end
        run = 1'b0;
        step();
    endtask

    task automatic test_load_tick();
        do_load(16'h0230);
        run = 1'b1;
        step();
        load = 1'b1;
        data = 16'h0500;
        tick = 1'b1;
        step();
        load = 1'b0;
        tick = 1'b0;
        total++; if (count !== 16'h0500) begin bad++; $display("FAIL loadtick_count got=%h exp=%h", count, 16'h0500); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL loadtick_done got=%b exp=0", done); end
        total++; if (state_dbg !== ARMED) begin bad++; $display("FAIL loadtick_state got=%0d exp=%0d", state_dbg, ARMED); end
        do_load(16'h0000);
        total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL loadzero_state got=%0d exp=%0d", state_dbg, IDLE); end
        run = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_load(16'h0042);
        run = 1'b1;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (count !== 16'h0000) begin bad++; $display("FAIL rstmid_count got=%h exp=%h", count, 16'h0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        total++; if (tc !== 1'b1) begin bad++; $display("FAIL rstmid_tc got=%b exp=1", tc); end
        reset = 1'b1;
        run   = 1'b0;
        step();
    endtask

    task automatic test_over_max();
        logic [15:0] exp_load;
        logic [15:0] exp_dec;
`ifdef BCD_TIMER_CLAMP_EN
        exp_load = 16'h9959;
        exp_dec  = 16'h9958;
`else
        exp_load = 16'h9999;
        exp_dec  = 16'h9998;
`endif
        do_load(16'h9999);
        total++; if (count !== exp_load) begin bad++; $display("FAIL overmax_load got=%h exp=%h", count, exp_load); end
        run = 1'b1;
        step();
        do_tick();
        total++; if (count !== exp_dec) begin bad++; $display("FAIL overmax_dec got=%h exp=%h", count, exp_dec); end
        run = 1'b0;
        step();
    endtask

    initial begin
        load  = 1'b0;
        data  = 16'h0000;
        run   = 1'b0;
        tick  = 1'b0;
        reset = 1'b0;
        test_reset();
        test_basic_expire();
        test_borrow();
        test_pause();
        test_wrap();
        test_load_tick();
        test_reset_mid();
        test_over_max();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_timer_chain.md
Name: bcd_timer_chain

Overview:
- Parametrised multi-digit BCD down-counter for the microwave cook timer.
- Successor to the single mod-10 digit counter. Digits are cascaded with borrow, and each digit has its own modulus (MM:SS needs a mod-6 tens-of-seconds digit).
- Adds a time-base enable, a run/expire state machine, a one-cycle done pulse and an optional wrap mode.
- Sits between keypad load logic and the 7-segment display driver.

Parameters:
- NUM_DIGITS, 4, number of cascaded BCD digits; digit 0 is least significant.
- DIGIT_MAX, 16'h9959, packed 4 bits per digit (digit 0 in [3:0]); the maximum value of each digit, reloaded on borrow. The default is M-tens 9, M-units 9, S-tens 5, S-units 9.
- WRAP_EN, 0, selects the behaviour at all-zero: 0 = stop; 1 = wrap to the all-DIGIT_MAX value and keep running.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load of data; highest priority after reset.
- data  input  4*NUM_DIGITS  BCD preset value.
- run  input  1  level; 1 = count, 0 = pause (hold).
- tick  input  1  one-cycle time-base strobe, e.g. 1 Hz; decrements only happen on tick.
- count  output  4*NUM_DIGITS  current BCD value, registered.
- tc  output  1  combinational; 1 when count == 0.
- busy  output  1  1 while in the RUNNING state.
- done  output  1  registered one-cycle pulse when a decrement reaches zero.

Behaviour:
- Reset (reset=0, asynchronous) forces these values:
  - count = 0
  - state = IDLE
  - done = 0
  - busy = 0
  - tc = 1
- Update priority each posedge: reset > load > decrement > hold.
- Load: count <= data on the next edge.
  - Any pending tick in that cycle is discarded.
  - done is forced to 0.
  - Next state is ARMED if data != 0, otherwise IDLE.
- Decrement condition: state == RUNNING and tick == 1.
- Borrow chain:
  - Digit 0 always receives borrow-in = 1 on a decrement.
  - Digit i receives borrow-in = 1 iff digits 0..i-1 are all 0.
  - A digit with borrow-in: if 0 it becomes DIGIT_MAX[i], otherwise it becomes digit - 1 (4-bit binary).
  - No BCD correction beyond that. A loaded digit greater than its DIGIT_MAX counts down through binary values until it wraps.
- Latency: count changes on the edge where tick is sampled high; one decrement per tick.
- FSM states: IDLE, ARMED, RUNNING, EXPIRED. Encoding comes from the package.
  - IDLE: count == 0. Goes to ARMED on a load of a nonzero value. run is ignored.
  - ARMED: goes to RUNNING when run == 1.
  - RUNNING: goes back to ARMED when run == 0 (pause; count held, ticks ignored).
  - RUNNING, decrement from count == 1 (reaching 0), WRAP_EN == 0: go to EXPIRED, done = 1 for one cycle.
  - RUNNING, decrement from count == 1, WRAP_EN == 1: done = 1 for one cycle, count becomes 0. The next tick loads all-DIGIT_MAX and the state stays RUNNING.
  - EXPIRED: count held at 0 and ticks ignored. Goes to IDLE on the next cycle in which run == 0, or goes to ARMED/IDLE on a load.
- busy = (state == RUNNING).
- Simultaneous events:
  - load and tick in the same cycle: load wins.
  - run falling and tick in the same cycle: the tick is ignored (pause takes effect immediately).
- Reset asserted mid-count clears everything at once; no done pulse.

Optional Feature:
- Macro: BCD_TIMER_CLAMP_EN.
- Defined: on load, each data digit greater than DIGIT_MAX[i] is stored as DIGIT_MAX[i] (e.g. 99:99 loads as 99:59).
- Undefined: data is stored unmodified and decrements as described under Behaviour.

Decomposition:
- Package bcd_timer_pkg:
  - DIGIT_W = 4
  - state typedef/localparams IDLE, ARMED, RUNNING, EXPIRED
  - function returning the max digit for index i from DIGIT_MAX
- Sub-module bcd_digit_cell, generated NUM_DIGITS times:
  - Inputs: clk, reset, load, load value, max value, borrow_in, dec_en.
  - Outputs: digit, is_zero.
  - The top level builds the borrow chain from the is_zero outputs and holds the FSM.

Test Plan:
- Reset, then load data=16'h0003, run=1, 3 ticks: count goes 0003→0002→0001→0000; done is high exactly 1 cycle after the 3rd tick edge; state EXPIRED; tc=1.
- Load 16'h0100, run=1, 1 tick: count = 16'h0059 (seconds borrow reloads 5/9, minute units 1→0).
- Load 16'h0010 and run, 2 ticks, drop run for 5 ticks, raise run, 1 tick: count goes 0009→0008, holds at 0008 during the pause, then goes to 0007.
- WRAP_EN=1, load 16'h0001, run, 2 ticks: first tick gives count 0 and done pulse; second tick gives count = 16'h9959 and busy stays 1.
- load=1 with data=16'h0500 in the same cycle as tick while RUNNING at 16'h0230: count = 16'h0500 (not 0229); done = 0.
- Assert reset low mid-count at 16'h0042 between edges: count = 0 immediately, done = 0, busy = 0. With BCD_TIMER_CLAMP_EN defined, loading 16'h9999 gives count = 16'h9959.
